// File: rtl/pipe_ctrl_defs.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encodings and the default counter width.
package pipe_ctrl_defs;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DWAIT  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on reset, increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // Count qualifying cycles, holding at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (inc)
      value <= sat_inc(value);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush arbiter for the cached 5-stage pipeline.
// Resolves D-cache freeze, load-use stall, ID redirect, JPR/JRL PC stall and
// I-cache miss into pipeline-register enables and NOP-insertion controls,
// freezes across D-misses and latches HALT.
// Optional macro PERF_CNT_EN adds per-cause saturating performance counters.
module pipeline_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             stall_pc,
  input  logic             redirect,
  input  logic             i_req,
  input  logic             i_ready,
  input  logic             d_req,
  input  logic             d_ready,
  input  logic             halt_wb,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             mem_wb_bubble,
  output logic             halted,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] dmiss_cycles,
  output logic [CNT_W-1:0] imiss_cycles,
  output logic [CNT_W-1:0] loaduse_cycles,
  output logic [CNT_W-1:0] flush_count,
`endif
  output logic [CNT_W-1:0] stall_cycles
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       live;
  logic       dfreeze;
  logic       dexit;
  logic       imiss;
  logic       halt_acc;
  logic       win_loaduse;
  logic       win_redirect;
  logic       win_imiss;

  // Classify this cycle: who owns the pipe and whether a D-access is pending
  always_comb begin
    live      = !reset && (state != ST_HALTED);
    dfreeze   = ((state == ST_DWAIT) && !d_ready) ||
                ((state == ST_RUN) && d_req && !d_ready);
    dexit     = (state == ST_DWAIT) && d_ready;
    imiss     = i_req && !i_ready;
    halt_acc  = live && !dfreeze && halt_wb;
  end

  // Priority resolution into register enables and NOP controls
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_write  = 1'b0;
    mem_wb_bubble = 1'b0;
    win_loaduse   = 1'b0;
    win_redirect  = 1'b0;
    win_imiss     = 1'b0;
    if (live && !dfreeze) begin
      // Store finishing a freeze: WB receives a NOP (datapath qualifies it)
      mem_wb_bubble = dexit;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      mem_wb_write  = 1'b1;
      if (stall) begin
        // Redirect dropped: branch operands not ready, ID re-raises it
        id_ex_bubble = 1'b1;
        win_loaduse  = 1'b1;
      end else if (redirect) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        win_redirect = 1'b1;
      end else if (stall_pc || imiss) begin
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        win_imiss    = !stall_pc;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
      end
    end
  end

  // Next-state: halt only once WB can commit, D-wait until the cache answers
  always_comb begin
    state_nxt = state;
    if (halt_acc)
      state_nxt = ST_HALTED;
    else if ((state == ST_RUN) && d_req && !d_ready)
      state_nxt = ST_DWAIT;
    else if (dexit)
      state_nxt = ST_RUN;
  end

  // FSM register; reset abandons any outstanding D-wait
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  // Sticky halt flag, visible the cycle after the HLT commits
  always_ff @(posedge clk) begin
    if (reset)
      halted <= 1'b0;
    else if (halt_acc)
      halted <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (live && !pc_write),
    .value (stall_cycles)
  );

`ifdef PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_dmiss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (live && dfreeze),
    .value (dmiss_cycles)
  );

  sat_counter #(.W(CNT_W)) u_imiss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (win_imiss),
    .value (imiss_cycles)
  );

  sat_counter #(.W(CNT_W)) u_loaduse_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (win_loaduse),
    .value (loaduse_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (win_redirect),
    .value (flush_count)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a 4-bit-counter instance and a default-width
// instance share the same stimulus.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset, stall, stall_pc, redirect, i_req, i_ready, d_req, d_ready, halt_wb;

  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic ex_mem_write, mem_wb_write, mem_wb_bubble, halted;
  logic [3:0] stall_cycles;

  logic b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write, b_id_ex_bubble;
  logic b_ex_mem_write, b_mem_wb_write, b_mem_wb_bubble, b_halted;
  logic [15:0] b_stall_cycles;

`ifdef PERF_CNT_EN
  logic [3:0]  dmiss_cycles, imiss_cycles, loaduse_cycles, flush_count;
  logic [15:0] b_dmiss_cycles, b_imiss_cycles, b_loaduse_cycles, b_flush_count;
`endif

  int evaluated = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pc(stall_pc), .redirect(redirect),
    .i_req(i_req), .i_ready(i_ready), .d_req(d_req), .d_ready(d_ready), .halt_wb(halt_wb),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .mem_wb_write(mem_wb_write), .mem_wb_bubble(mem_wb_bubble), .halted(halted),
`ifdef PERF_CNT_EN
    .dmiss_cycles(dmiss_cycles), .imiss_cycles(imiss_cycles),
    .loaduse_cycles(loaduse_cycles), .flush_count(flush_count),
`endif
    .stall_cycles(stall_cycles)
  );

  pipeline_ctrl dut_wide (
    .clk(clk), .reset(reset), .stall(stall), .stall_pc(stall_pc), .redirect(redirect),
    .i_req(i_req), .i_ready(i_ready), .d_req(d_req), .d_ready(d_ready), .halt_wb(halt_wb),
    .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_ex_write(b_id_ex_write), .id_ex_bubble(b_id_ex_bubble), .ex_mem_write(b_ex_mem_write),
    .mem_wb_write(b_mem_wb_write), .mem_wb_bubble(b_mem_wb_bubble), .halted(b_halted),
`ifdef PERF_CNT_EN
    .dmiss_cycles(b_dmiss_cycles), .imiss_cycles(b_imiss_cycles),
    .loaduse_cycles(b_loaduse_cycles), .flush_count(b_flush_count),
`endif
    .stall_cycles(b_stall_cycles)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb} enables and {if_id_flush, id_ex_bubble, mem_wb_bubble}
  logic [4:0] writes;
  logic [2:0] flags;
  assign writes = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write};
  assign flags  = {if_id_flush, id_ex_bubble, mem_wb_bubble};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; stall_pc = 0; redirect = 0; i_req = 0; i_ready = 0;
    d_req = 0; d_ready = 0; halt_wb = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    chk("reset_writes", 32'(writes), 32'h00);
    chk("reset_flags", 32'(flags), 32'h0);

    reset = 1'b0;
    #1;
    chk("idle_writes", 32'(writes), 32'h1f);
    chk("idle_flags", 32'(flags), 32'h0);
    chk("idle_halted", 32'(halted), 32'h0);
    chk("idle_stallcnt", 32'(stall_cycles), 32'h0);

    // Load-use beats redirect
    stall = 1; redirect = 1;
    #1;
    chk("loaduse_writes", 32'(writes), 32'h07);
    chk("loaduse_flags", 32'(flags), 32'h2);
    tick();
    clear_in();
    chk("loaduse_cnt", 32'(stall_cycles), 32'd1);

    // D-miss: three frozen cycles, then release on d_ready (store exit bubble)
    d_req = 1; d_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dfreeze_writes", 32'(writes), 32'h00);
      tick();
    end
    d_ready = 1;
    #1;
    chk("dexit_writes", 32'(writes), 32'h1f);
    chk("dexit_flags", 32'(flags), 32'h1);
    tick();
    clear_in();
    chk("dmiss_cnt", 32'(stall_cycles), 32'd4);

    // Redirect overrides stall_pc and I-miss
    redirect = 1; i_req = 1; i_ready = 0; stall_pc = 1;
    #1;
    chk("redirect_writes", 32'(writes), 32'h1f);
    chk("redirect_flags", 32'(flags), 32'h4);
    tick();
    clear_in();
    chk("redirect_cnt", 32'(stall_cycles), 32'd4);

    // JPR/JRL PC stall
    stall_pc = 1;
    #1;
    chk("stallpc_writes", 32'(writes), 32'h0f);
    chk("stallpc_flags", 32'(flags), 32'h4);
    tick();
    clear_in();
    chk("stallpc_cnt", 32'(stall_cycles), 32'd5);

    // I-cache miss
    i_req = 1; i_ready = 0;
    #1;
    chk("imiss_writes", 32'(writes), 32'h0f);
    chk("imiss_flags", 32'(flags), 32'h4);
    tick();
    clear_in();
    chk("imiss_cnt", 32'(stall_cycles), 32'd6);

    // Halt arriving during a D-freeze waits for the release
    d_req = 1; d_ready = 0; halt_wb = 1;
    #1;
    chk("halt_frz1_writes", 32'(writes), 32'h00);
    tick();
    #1;
    chk("halt_frz2_writes", 32'(writes), 32'h00);
    chk("halt_frz2_halted", 32'(halted), 32'h0);
    tick();
    d_ready = 1;
    #1;
    chk("halt_rel_writes", 32'(writes), 32'h1f);
    chk("halt_rel_halted", 32'(halted), 32'h0);
    tick();
    clear_in();
    chk("halted_set", 32'(halted), 32'h1);
    chk("halt_cnt", 32'(stall_cycles), 32'd8);
    stall = 1; redirect = 1; d_req = 1;
    #1;
    chk("halted_writes", 32'(writes), 32'h00);
    chk("halted_flags", 32'(flags), 32'h0);
    tick();
    clear_in();
    #1;
    chk("halted_writes_idle", 32'(writes), 32'h00);
    chk("halted_sticky", 32'(halted), 32'h1);
    chk("halted_cnt_frozen", 32'(stall_cycles), 32'd8);

    // Reset leaves HALTED
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("post_halt_halted", 32'(halted), 32'h0);
    chk("post_halt_cnt", 32'(stall_cycles), 32'h0);
    chk("post_halt_writes", 32'(writes), 32'h1f);

    // Saturation: 2^4 + 5 stall cycles
    stall = 1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_mid", 32'(stall_cycles), 32'd14);
    for (int i = 0; i < 7; i++) tick();
    chk("sat_hold", 32'(stall_cycles), 32'd15);
    chk("sat_wide", 32'(b_stall_cycles), 32'd21);
    clear_in();

    // Reset in the middle of a D-wait returns straight to RUN
    d_req = 1; d_ready = 0;
    tick();
    #1;
    chk("dwait_writes", 32'(writes), 32'h00);
    reset = 1;
    #1;
    chk("dwait_reset_writes", 32'(writes), 32'h00);
    tick();
    reset = 0; d_req = 0;
    #1;
    chk("dwait_after_reset", 32'(writes), 32'h1f);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
